// File: rtl/mii_tx_scheduler.sv
// mii_tx_scheduler: round-robin arbiter that shares one 64-bit MII frame
// generator between NUM_REQ MAC-frame sources. A granted frame is
// length-checked, launched with tx_en for LAUNCH_CYCLES, streamed as
// ceil(len/8) valid words, closed with a done pulse and followed by an
// IPG_CYCLES idle gap. Illegal lengths are dropped with a reject pulse.
// Optional statistics counters are built when MII_SCHED_STATS_EN is defined;
// otherwise o_frame_cnt and o_drop_cnt are tied to zero.
module mii_tx_scheduler #(
  parameter int NUM_REQ         = 2,
  parameter int LEN_W           = 16,
  parameter int MIN_FRAME_BYTES = 22,
  parameter int MAX_FRAME_BYTES = 1514,
  parameter int LAUNCH_CYCLES   = 2,
  parameter int IPG_CYCLES      = 2
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*LEN_W-1:0] i_req_len,
  input  logic [NUM_REQ*64-1:0]    i_req_data,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_REQ-1:0]       o_data_rd,
  output logic [NUM_REQ-1:0]       o_reject,
  output logic                     o_mii_tx_en,
  output logic                     o_valid,
  output logic [63:0]              o_mii_tx_d,
  output logic                     o_mac_done,
  output logic                     o_busy,
  output logic [31:0]              o_frame_cnt,
  output logic [15:0]              o_drop_cnt
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WCNT_W  = LEN_W - 3;
  localparam int TMR_MAX = (LAUNCH_CYCLES > IPG_CYCLES) ? LAUNCH_CYCLES : IPG_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REJECT,
    ST_LAUNCH,
    ST_STREAM,
    ST_DONE,
    ST_GAP
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   cur_idx;
  logic [LEN_W-1:0]   cur_len;
  logic [WCNT_W-1:0]  word_cnt;
  logic [TMR_W-1:0]   tmr;

  logic [LEN_W-1:0]   len_arr  [NUM_REQ];
  logic [63:0]        data_arr [NUM_REQ];

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [LEN_W-1:0]   pick_len;
  logic               pick_legal;
  logic [IDX_W-1:0]   rr_next;
  logic [WCNT_W-1:0]  len_words;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign len_arr[g]  = i_req_len[g*LEN_W +: LEN_W];
    assign data_arr[g] = i_req_data[g*64 +: 64];
  end

  // Round-robin pick: first requesting index at or above the pointer, wrapping.
  always_comb begin
    int cand;
    cand       = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_found && i_req[IDX_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  assign pick_len   = len_arr[pick_idx];
  assign pick_legal = (pick_len >= LEN_W'(MIN_FRAME_BYTES)) && (pick_len <= LEN_W'(MAX_FRAME_BYTES));
  assign rr_next    = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
  assign len_words  = WCNT_W'((cur_len + LEN_W'(7)) >> 3);

  // Frame sequencing FSM; every generator-facing output is registered here.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      cur_idx     <= '0;
      cur_len     <= '0;
      word_cnt    <= '0;
      tmr         <= '0;
      o_grant     <= '0;
      o_data_rd   <= '0;
      o_reject    <= '0;
      o_mii_tx_en <= 1'b0;
      o_valid     <= 1'b0;
      o_mac_done  <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_reject   <= '0;
      o_mac_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            cur_idx <= pick_idx;
            cur_len <= pick_len;
            rr_ptr  <= rr_next;
            o_busy  <= 1'b1;
            if (pick_legal) begin
              state       <= ST_LAUNCH;
              o_grant     <= NUM_REQ'(1) << pick_idx;
              o_mii_tx_en <= 1'b1;
              tmr         <= TMR_W'(LAUNCH_CYCLES - 1);
            end else begin
              state    <= ST_REJECT;
              o_reject <= NUM_REQ'(1) << pick_idx;
            end
          end
        end
        ST_REJECT: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
        ST_LAUNCH: begin
          if (tmr == '0) begin
            state     <= ST_STREAM;
            o_valid   <= 1'b1;
            o_data_rd <= NUM_REQ'(1) << cur_idx;
            word_cnt  <= len_words;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        ST_STREAM: begin
          if (word_cnt == WCNT_W'(1)) begin
            state       <= ST_DONE;
            o_mii_tx_en <= 1'b0;
            o_valid     <= 1'b0;
            o_data_rd   <= '0;
            o_grant     <= '0;
            o_mac_done  <= 1'b1;
          end else begin
            word_cnt <= word_cnt - WCNT_W'(1);
          end
        end
        ST_DONE: begin
          if (IPG_CYCLES == 0) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else begin
            state <= ST_GAP;
            tmr   <= TMR_W'(IPG_CYCLES - 1);
          end
        end
        ST_GAP: begin
          if (tmr == '0) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        default: begin
          state       <= ST_IDLE;
          o_grant     <= '0;
          o_data_rd   <= '0;
          o_mii_tx_en <= 1'b0;
          o_valid     <= 1'b0;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Data path is a straight mux of the owner's current word, zeroed when idle.
  always_comb begin
    o_mii_tx_d = '0;
    if (o_valid) o_mii_tx_d = data_arr[cur_idx];
  end

`ifdef MII_SCHED_STATS_EN
  logic frame_evt;
  logic drop_evt;

  assign frame_evt = (state == ST_STREAM) && (word_cnt == WCNT_W'(1));
  assign drop_evt  = (state == ST_IDLE) && pick_found && !pick_legal;

  // Completed-frame counter wraps; drop counter saturates at all-ones.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_frame_cnt <= '0;
      o_drop_cnt  <= '0;
    end else begin
      if (frame_evt) o_frame_cnt <= o_frame_cnt + 32'd1;
      if (drop_evt && (o_drop_cnt != 16'hFFFF)) o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end
`else
  assign o_frame_cnt = '0;
  assign o_drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_mii_tx_scheduler.sv
// Testbench for mii_tx_scheduler. Keeps its own round-robin pointer, frame
// timeline and statistics model, and plays requesters whose data words are a
// per-requester salted sequence. Counter expectations follow
// MII_SCHED_STATS_EN the same way the design does.
module tb_mii_tx_scheduler;

  localparam int NREQ = 2;
  localparam int LW   = 16;
  localparam int MINB = 22;
  localparam int MAXB = 1514;
  localparam int L    = 2;
  localparam int IPG  = 2;

  logic                 clk = 1'b0;
  logic                 i_rst;
  logic [NREQ-1:0]      i_req;
  logic [NREQ*LW-1:0]   i_req_len;
  logic [NREQ*64-1:0]   i_req_data;
  logic [NREQ-1:0]      o_grant;
  logic [NREQ-1:0]      o_data_rd;
  logic [NREQ-1:0]      o_reject;
  logic                 o_mii_tx_en;
  logic                 o_valid;
  logic [63:0]          o_mii_tx_d;
  logic                 o_mac_done;
  logic                 o_busy;
  logic [31:0]          o_frame_cnt;
  logic [15:0]          o_drop_cnt;

  int checks = 0;
  int errors = 0;

  int              model_rr;
  int              model_frames;
  int              model_drops;
  int              word_pos [NREQ];
  logic [63:0]     salt [NREQ];
  logic [NREQ-1:0] req_mask;
  int              req_lens [NREQ];

  always #5 clk = ~clk;

  mii_tx_scheduler #(
    .NUM_REQ(NREQ), .LEN_W(LW), .MIN_FRAME_BYTES(MINB), .MAX_FRAME_BYTES(MAXB),
    .LAUNCH_CYCLES(L), .IPG_CYCLES(IPG)
  ) dut (
    .clk(clk), .i_rst(i_rst), .i_req(i_req), .i_req_len(i_req_len), .i_req_data(i_req_data),
    .o_grant(o_grant), .o_data_rd(o_data_rd), .o_reject(o_reject), .o_mii_tx_en(o_mii_tx_en),
    .o_valid(o_valid), .o_mii_tx_d(o_mii_tx_d), .o_mac_done(o_mac_done), .o_busy(o_busy),
    .o_frame_cnt(o_frame_cnt), .o_drop_cnt(o_drop_cnt)
  );

  function automatic logic [63:0] word_of(input int k, input int pos);
    return salt[k] ^ {32'(pos), 32'(pos * 7 + k)};
  endfunction

  function automatic logic [31:0] exp_frames();
`ifdef MII_SCHED_STATS_EN
    return 32'(model_frames);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [15:0] exp_drops();
`ifdef MII_SCHED_STATS_EN
    return 16'(model_drops);
`else
    return 16'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_data();
    for (int k = 0; k < NREQ; k++) i_req_data[k*64 +: 64] = word_of(k, word_pos[k]);
  endtask

  task automatic drive_req();
    i_req = req_mask;
    for (int k = 0; k < NREQ; k++) i_req_len[k*LW +: LW] = LW'(req_lens[k]);
  endtask

  task automatic scramble_inputs();
    i_req = NREQ'($urandom);
    for (int k = 0; k < NREQ; k++) i_req_len[k*LW +: LW] = LW'($urandom);
  endtask

  // One arbitration round starting in an IDLE cycle: the model decides the
  // winner and whether it is legal, then every cycle of the round is checked.
  task automatic serve(input bit scramble);
    int k, c, len, w, last;
    bit found;
    logic tx_en_e, valid_e, done_e, busy_e;
    logic [NREQ-1:0] grant_e, rd_e;
    logic [63:0] d_e;
    found = 1'b0;
    k = 0;
    for (int i = 0; i < NREQ; i++) begin
      c = (model_rr + i) % NREQ;
      if (!found && req_mask[c]) begin found = 1'b1; k = c; end
    end
    if (!found) begin
      tick(); drive_data(); #1;
      checks++;
      if (o_busy !== 1'b0 || o_mii_tx_en !== 1'b0 || o_grant !== '0) begin
        errors++;
        $display("[TB] FAIL idle_no_req: busy=%b tx_en=%b grant=%b expected 0 0 0", o_busy, o_mii_tx_en, o_grant);
      end
      return;
    end
    model_rr = (k + 1) % NREQ;
    len = req_lens[k];
    if (len < MINB || len > MAXB) begin
      if (model_drops < 65535) model_drops++;
      tick(); drive_data(); #1;
      checks++;
      if (o_reject !== NREQ'(1 << k)) begin errors++; $display("[TB] FAIL reject k=%0d len=%0d: got %b expected %b", k, len, o_reject, NREQ'(1 << k)); end
      checks++;
      if (o_grant !== '0 || o_mii_tx_en !== 1'b0 || o_valid !== 1'b0 || o_busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reject_outs k=%0d: grant=%b tx_en=%b valid=%b busy=%b expected 0 0 0 1", k, o_grant, o_mii_tx_en, o_valid, o_busy);
      end
      if (scramble) scramble_inputs();
      tick(); drive_data(); #1;
      checks++;
      if (o_reject !== '0 || o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reject_end: reject=%b busy=%b expected 0 0", o_reject, o_busy); end
      checks++;
      if (o_drop_cnt !== exp_drops()) begin errors++; $display("[TB] FAIL drop_cnt: got %0d expected %0d", o_drop_cnt, exp_drops()); end
      return;
    end
    w = (len + 7) / 8;
    last = L + w + IPG + 2;
    for (int n = 1; n <= last; n++) begin
      tick(); drive_data(); #1;
      tx_en_e = (n <= L + w);
      valid_e = (n >= L + 1) && (n <= L + w);
      done_e  = (n == L + w + 1);
      busy_e  = (n <= L + w + 1 + IPG);
      grant_e = tx_en_e ? NREQ'(1 << k) : '0;
      rd_e    = valid_e ? NREQ'(1 << k) : '0;
      d_e     = valid_e ? word_of(k, word_pos[k]) : 64'h0;
      checks++;
      if (o_mii_tx_en !== tx_en_e) begin errors++; $display("[TB] FAIL tx_en k=%0d len=%0d n=%0d: got %b expected %b", k, len, n, o_mii_tx_en, tx_en_e); end
      checks++;
      if (o_valid !== valid_e) begin errors++; $display("[TB] FAIL valid k=%0d len=%0d n=%0d: got %b expected %b", k, len, n, o_valid, valid_e); end
      checks++;
      if (o_grant !== grant_e) begin errors++; $display("[TB] FAIL grant k=%0d len=%0d n=%0d: got %b expected %b", k, len, n, o_grant, grant_e); end
      checks++;
      if (o_data_rd !== rd_e) begin errors++; $display("[TB] FAIL data_rd k=%0d len=%0d n=%0d: got %b expected %b", k, len, n, o_data_rd, rd_e); end
      checks++;
      if (o_mac_done !== done_e) begin errors++; $display("[TB] FAIL mac_done k=%0d len=%0d n=%0d: got %b expected %b", k, len, n, o_mac_done, done_e); end
      checks++;
      if (o_busy !== busy_e) begin errors++; $display("[TB] FAIL busy k=%0d len=%0d n=%0d: got %b expected %b", k, len, n, o_busy, busy_e); end
      checks++;
      if (o_reject !== '0) begin errors++; $display("[TB] FAIL reject_in_frame n=%0d: got %b expected 0", n, o_reject); end
      checks++;
      if (o_mii_tx_d !== d_e) begin errors++; $display("[TB] FAIL tx_d k=%0d n=%0d: got %h expected %h", k, n, o_mii_tx_d, d_e); end
      if (valid_e) word_pos[k]++;
      if (done_e) model_frames++;
      if (scramble && n < last) scramble_inputs();
    end
    checks++;
    if (o_frame_cnt !== exp_frames()) begin errors++; $display("[TB] FAIL frame_cnt: got %0d expected %0d", o_frame_cnt, exp_frames()); end
    checks++;
    if (o_drop_cnt !== exp_drops()) begin errors++; $display("[TB] FAIL drop_cnt: got %0d expected %0d", o_drop_cnt, exp_drops()); end
  endtask

  task automatic test_reset();
    for (int k = 0; k < NREQ; k++) begin
      salt[k] = {$urandom, $urandom};
      word_pos[k] = 0;
      req_lens[k] = 0;
    end
    model_rr = 0; model_frames = 0; model_drops = 0;
    req_mask = '0;
    i_rst = 1'b1;
    drive_req();
    drive_data();
    repeat (3) tick();
    checks++;
    if (o_grant !== '0 || o_data_rd !== '0 || o_reject !== '0) begin
      errors++; $display("[TB] FAIL reset_vectors: grant=%b data_rd=%b reject=%b expected 0", o_grant, o_data_rd, o_reject);
    end
    checks++;
    if (o_mii_tx_en !== 1'b0 || o_valid !== 1'b0 || o_mac_done !== 1'b0 || o_busy !== 1'b0 || o_mii_tx_d !== 64'h0) begin
      errors++; $display("[TB] FAIL reset_flags: tx_en=%b valid=%b done=%b busy=%b d=%h expected 0", o_mii_tx_en, o_valid, o_mac_done, o_busy, o_mii_tx_d);
    end
    checks++;
    if (o_frame_cnt !== 32'd0 || o_drop_cnt !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_counters: frames=%0d drops=%0d expected 0 0", o_frame_cnt, o_drop_cnt);
    end
    i_rst = 1'b0;
    serve(1'b0);
  endtask

  task automatic test_single_frame();
    req_mask = 2'b01; req_lens[0] = 22; req_lens[1] = 64;
    drive_req();
    serve(1'b0);
    req_mask = '0; drive_req();
    serve(1'b0);
  endtask

  task automatic test_back_to_back();
    req_mask = 2'b11; req_lens[0] = 64; req_lens[1] = 64;
    drive_req();
    repeat (4) serve(1'b0);
    req_mask = '0; drive_req();
  endtask

  task automatic test_reject();
    req_mask = 2'b10; req_lens[1] = 21; drive_req();
    serve(1'b0);
    req_lens[1] = 1515; drive_req();
    serve(1'b0);
    req_mask = 2'b11; req_lens[0] = 30; req_lens[1] = 1515; drive_req();
    serve(1'b0);
    serve(1'b0);
    req_mask = '0; drive_req();
  endtask

  task automatic test_boundaries();
    req_mask = 2'b01; req_lens[0] = 1514; drive_req();
    serve(1'b0);
    req_lens[0] = 23; drive_req();
    serve(1'b0);
    req_mask = 2'b10; req_lens[1] = 22; drive_req();
    serve(1'b0);
    req_mask = '0; drive_req();
  endtask

  task automatic test_random();
    int r;
    for (int it = 0; it < 30; it++) begin
      req_mask = NREQ'($urandom_range(0, 3));
      for (int k = 0; k < NREQ; k++) begin
        r = $urandom_range(0, 11);
        if (r == 0) req_lens[k] = $urandom_range(0, 21);
        else if (r == 1) req_lens[k] = $urandom_range(1515, 4000);
        else if (r == 2) req_lens[k] = 22;
        else if (r == 3) req_lens[k] = $urandom_range(1400, 1514);
        else req_lens[k] = $urandom_range(22, 120);
      end
      drive_req();
      serve(1'b1);
    end
    req_mask = '0; drive_req();
  endtask

  task automatic test_mid_reset();
    req_mask = 2'b01; req_lens[0] = 64; drive_req();
    for (int n = 1; n <= L + 2; n++) begin
      tick(); drive_data(); #1;
      if (n >= L + 1) word_pos[0]++;
    end
    checks++;
    if (o_valid !== 1'b1 || o_data_rd !== 2'b01) begin
      errors++; $display("[TB] FAIL pre_reset_stream: valid=%b data_rd=%b expected 1 01", o_valid, o_data_rd);
    end
    i_rst = 1'b1;
    tick(); #1;
    checks++;
    if (o_grant !== '0 || o_data_rd !== '0 || o_mii_tx_en !== 1'b0 || o_valid !== 1'b0 || o_mii_tx_d !== 64'h0) begin
      errors++; $display("[TB] FAIL abort_outputs: grant=%b rd=%b tx_en=%b valid=%b d=%h expected 0", o_grant, o_data_rd, o_mii_tx_en, o_valid, o_mii_tx_d);
    end
    checks++;
    if (o_mac_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_done: done=%b busy=%b expected 0 0", o_mac_done, o_busy);
    end
    checks++;
    if (o_frame_cnt !== 32'd0 || o_drop_cnt !== 16'd0) begin
      errors++; $display("[TB] FAIL abort_counters: frames=%0d drops=%0d expected 0 0", o_frame_cnt, o_drop_cnt);
    end
    i_rst = 1'b0;
    model_rr = 0; model_frames = 0; model_drops = 0;
    for (int k = 0; k < NREQ; k++) word_pos[k] = 0;
    drive_data();
    req_mask = 2'b11; req_lens[0] = 40; req_lens[1] = 48; drive_req();
    serve(1'b0);
    req_mask = '0; drive_req();
    serve(1'b0);
  endtask

  // Scenario sequence; each task leaves the scheduler idle for the next one.
  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reject();
    test_boundaries();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
